// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with registered operands and a valid/ready result port
// Single-cycle ops finish in one EXEC cycle; MUL/DIVU/REMU iterate one bit per cycle in BUSY first.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SHAMT_W-1:0] cnt;
  // acc: product accumulator or partial remainder; sh_x: multiplicand or quotient; sh_y: multiplier
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   sh_x;
  logic [WIDTH-1:0]   sh_y;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   exec_val;
  logic               exec_ill;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic               accept_multi;

  assign in_ready     = (state == S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign accept_multi = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

  // Restoring division step: the borrow bit of the trial subtraction decides the quotient bit.
  assign div_shift = {acc, sh_x[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ok    = ~div_diff[WIDTH];

  always_comb begin
    shamt    = b_q[SHAMT_W-1:0];
    exec_val = '0;
    exec_ill = 1'b0;
    case (op_q)
      OP_ADD:  exec_val = a_q + b_q;
      OP_SUB:  exec_val = a_q - b_q;
      OP_AND:  exec_val = a_q & b_q;
      OP_OR:   exec_val = a_q | b_q;
      OP_NOR:  exec_val = ~(a_q | b_q);
      OP_XOR:  exec_val = a_q ^ b_q;
      OP_SLT:  exec_val = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: exec_val = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SLL:  exec_val = a_q << shamt;
      OP_SRL:  exec_val = a_q >> shamt;
      OP_SRA:  exec_val = $signed(a_q) >>> shamt;
      OP_MUL:  exec_val = acc;
      OP_DIVU: exec_val = sh_x;
      OP_REMU: exec_val = acc;
      default: exec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      acc        <= '0;
      sh_x       <= '0;
      sh_y       <= '0;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= alu_op;
            a_q   <= oprd1;
            b_q   <= oprd2;
            cnt   <= SHAMT_W'(WIDTH - 1);
            acc   <= '0;
            sh_x  <= oprd1;
            sh_y  <= oprd2;
            state <= accept_multi ? S_BUSY : S_EXEC;
          end
        end
        S_BUSY: begin
          if (op_q == OP_MUL) begin
            if (sh_y[0]) begin
              acc <= acc + sh_x;
            end
            sh_x <= sh_x << 1;
            sh_y <= sh_y >> 1;
          end else begin
            acc  <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            sh_x <= {sh_x[WIDTH-2:0], div_ok};
          end
          // Last iteration runs on the cycle the counter reads zero; EXEC then publishes it.
          if (cnt == '0) begin
            state <= S_EXEC;
          end else begin
            cnt <= cnt - SHAMT_W'(1);
          end
        end
        S_EXEC: begin
          result     <= exec_val;
          zero       <= (exec_val == '0);
          illegal_op <= exec_ill;
          state      <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed and randomized checks of alu_mc against a behavioural model
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] oprd1 = '0;
  logic [W-1:0] oprd2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .oprd1(oprd1), .oprd2(oprd2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  s;
    s = b[4:0];
    p = 64'(a) * 64'(b);
    case (op)
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b1100: return {1'b0, ~(a | b)};
      4'b0011: return {1'b0, a ^ b};
      4'b0111: return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      4'b1000: return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
      4'b0100: return {1'b0, a << s};
      4'b0101: return {1'b0, a >> s};
      4'b1101: return {1'b0, 32'($signed(a) >>> s)};
      4'b1001: return {1'b0, p[31:0]};
      4'b1010: return {1'b0, ((b == 0) ? 32'hFFFF_FFFF : a / b)};
      4'b1011: return {1'b0, ((b == 0) ? a : a % b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill, input int hold);
    int n;
    int lat;
    int exp_lat;
    bit rdy_seen;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'd1);
    alu_op    = op;
    oprd1     = a;
    oprd2     = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    oprd1    = $urandom;
    oprd2    = $urandom;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = (op == 4'b1001 || op == 4'b1010 || op == 4'b1011) ? W + 1 : 1;
    check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s.busy_in_ready", tag), 32'(rdy_seen), 32'd0);
    check($sformatf("%s.result", tag), result, exp_res);
    check($sformatf("%s.zero", tag), 32'(zero), 32'(exp_res == 32'd0));
    check($sformatf("%s.illegal", tag), 32'(illegal_op), 32'(exp_ill));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check($sformatf("%s.hold_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s.hold_result", tag), result, exp_res);
        check($sformatf("%s.hold_in_ready", tag), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("%s.release_valid", tag), 32'(out_valid), 32'd0);
      check($sformatf("%s.release_in_ready", tag), 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] m;

    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.illegal", 32'(illegal_op), 32'd0);
    rst = 1'b0;

    do_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 0);
    do_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    do_op("sltu",     4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    do_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 0);
    do_op("sra",      4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 0);
    do_op("sll",      4'b0100, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 0);
    do_op("mul_ovf",  4'b1001, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0, 0);
    do_op("mul",      4'b1001, 32'd12345, 32'd6789, 32'd83810205, 1'b0, 0);
    do_op("divu",     4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 0);
    do_op("remu",     4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 0);
    do_op("divu_z",   4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    do_op("remu_z",   4'b1011, 32'd9, 32'd0, 32'd9, 1'b0, 0);
    do_op("illegal",  4'b1111, 32'h1234, 32'h5678, 32'd0, 1'b1, 0);
    do_op("xor",      4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 0);
    do_op("hold_div", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 5);
    do_op("hold_add", 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 5);

    @(negedge clk);
    alu_op   = 4'b1001;
    oprd1    = 32'hDEAD;
    oprd2    = 32'hBEEF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 300);
        default: b = $urandom;
      endcase
      m = model(op, a, b);
      do_op($sformatf("rand%0d_op%0h", i, op), op, a, b, m[31:0], m[32], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
